cmd_parser: RTL and testbench

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 152 +++++++++++++++
 tb/tb_cmd_parser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// UART command-frame parser: SOF/CMD/ADDR/DATA/CHK frames drive a 4x8 register file
// and produce a one-byte ACK, NAK or read-data response with an inter-byte timeout.
module cmd_parser #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] led,
    output logic       frame_err
);

    localparam int unsigned CNT_W   = 19;
    localparam int unsigned NREGS   = 4;
    localparam int unsigned RADDR_W = 2;

    localparam logic [7:0] SOF      = 8'hAA;
    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;
    localparam logic [7:0] ADDR_MAX = 8'(NREGS - 1);

    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    // Reject configurations the 19-bit gap counter cannot represent.
    if (CLK_FREQ == 0 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (32'd1 << CNT_W)) begin : g_bad_cfg
        $error("cmd_parser: unsupported CLK_FREQ/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        RESP_WAIT,
        RESP_SEND
    } state_t;

    state_t state, state_nxt;

    logic             rx_valid_q;
    logic [7:0]       cmd_q, addr_q, data_q;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       regs [NREGS];
    logic             wr_pend;

    logic             accept_c;
    logic             in_frame_c;
    logic             timeout_c;
    logic             frame_ok_c;
    logic             load_resp_c;
    logic [7:0]       resp_c;

    assign accept_c   = rx_valid & ~rx_valid_q;
    assign in_frame_c = (state == GET_CMD) || (state == GET_ADDR) ||
                        (state == GET_DATA) || (state == GET_CHK);
    assign timeout_c  = in_frame_c && (gap_cnt == GAP_MAX);

    // Frame verdict is formed while the CHK byte is on rx_data so it is ready in EXEC.
    assign frame_ok_c  = ((cmd_q ^ addr_q ^ data_q) == rx_data) &&
                         ((cmd_q == CMD_WR) || (cmd_q == CMD_RD)) &&
                         (addr_q <= ADDR_MAX);
    assign load_resp_c = (state == GET_CHK) && accept_c && !timeout_c;

    always_comb begin
        resp_c = RESP_NAK;
        if (frame_ok_c) begin
            resp_c = (cmd_q == CMD_WR) ? RESP_ACK : regs[addr_q[RADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept_c && rx_data == SOF) state_nxt = GET_CMD;
            GET_CMD:   if (timeout_c) state_nxt = IDLE; else if (accept_c) state_nxt = GET_ADDR;
            GET_ADDR:  if (timeout_c) state_nxt = IDLE; else if (accept_c) state_nxt = GET_DATA;
            GET_DATA:  if (timeout_c) state_nxt = IDLE; else if (accept_c) state_nxt = GET_CHK;
            GET_CHK:   if (timeout_c) state_nxt = IDLE; else if (accept_c) state_nxt = EXEC;
            EXEC:      state_nxt = RESP_WAIT;
            RESP_WAIT: if (!tx_busy) state_nxt = RESP_SEND;
            RESP_SEND: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Receive edge detect, gap counter and frame field capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_valid_q <= 1'b0;
            gap_cnt    <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (!in_frame_c || accept_c) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end
            if (accept_c) begin
                case (state)
                    GET_CMD:  cmd_q  <= rx_data;
                    GET_ADDR: addr_q <= rx_data;
                    GET_DATA: data_q <= rx_data;
                    default:  ;
                endcase
            end
        end
    end

    // Response, error pulse, transmit request and register-file write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_data   <= '0;
            tx_start  <= 1'b0;
            frame_err <= 1'b0;
            wr_pend   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            frame_err <= load_resp_c && !frame_ok_c;
            tx_start  <= (state == RESP_WAIT) && !tx_busy;
            if (load_resp_c) begin
                tx_data <= resp_c;
                wr_pend <= frame_ok_c && (cmd_q == CMD_WR);
            end
            if (state == EXEC && wr_pend) begin
                regs[addr_q[RADDR_W-1:0]] <= data_q;
            end
        end
    end

    assign led = regs[0];

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized self-checking bench for cmd_parser against a frame-level reference model.
module tb_cmd_parser;

    localparam int unsigned TOUT = 200;
    localparam logic [7:0]  SOF  = 8'hAA;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] led;
    logic       frame_err;

    cmd_parser #(
        .CLK_FREQ      (50_000_000),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .led      (led),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every tx_start / frame_err pulse with its cycle.
    int         start_cnt = 0, start_cyc = -1, err_cnt = 0, err_cyc = -1;
    logic [7:0] start_data = 8'h00, err_data = 8'h00;
    always @(negedge clk) begin
        if (tx_start) begin
            start_cnt  = start_cnt + 1;
            start_cyc  = cyc;
            start_data = tx_data;
        end
        if (frame_err) begin
            err_cnt  = err_cnt + 1;
            err_cyc  = cyc;
            err_data = tx_data;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: the register file and the per-frame decision rules.
    logic [7:0] mregs [4];

    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                               input logic [7:0] chk, output logic [7:0] resp, output bit ok);
        ok = ((cmd ^ addr ^ data) == chk) && (cmd == 8'h01 || cmd == 8'h02) && (addr < 8'd4);
        if (!ok)                resp = NAK;
        else if (cmd == 8'h01) begin
            mregs[addr] = data;
            resp = ACK;
        end
        else                    resp = mregs[addr];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    endtask

    function automatic int rg();
        return int'($urandom_range(1, 4));
    endfunction

    // One strobe of random length; acc returns the cycle in which the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        acc      = cyc;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                             input logic [7:0] chk, input int busy, input int long_gap);
        logic [7:0] resp;
        bit         ok;
        int         s0, e0, acc, cc, exp_cyc;
        model_frame(cmd, addr, data, chk, resp, ok);
        s0 = start_cnt;
        e0 = err_cnt;
        if (busy > 0) tx_busy = 1'b1;
        send_byte(SOF, rg(), acc);
        send_byte(cmd, rg(), acc);
        send_byte(addr, (long_gap > 0) ? long_gap : rg(), acc);
        send_byte(data, rg(), acc);
        send_byte(chk, rg(), cc);
        exp_cyc = cc + 3;
        if (busy > 0) begin
            send_byte(SOF, 2, acc);
            idle(busy);
            check("busy_hold", 32'(start_cnt - s0), 0);
            tx_busy = 1'b0;
            exp_cyc = cyc + 1;
        end
        for (int i = 0; i < 50 && start_cnt == s0; i++) idle(1);
        check("start_count", 32'(start_cnt - s0), 1);
        check("start_latency", 32'(start_cyc), 32'(exp_cyc));
        check("tx_data", 32'(start_data), 32'(resp));
        check("err_count", 32'(err_cnt - e0), ok ? 0 : 1);
        if (!ok) begin
            check("err_cycle", 32'(err_cyc), 32'(cc + 1));
            check("err_tx_data", 32'(err_data), 32'(NAK));
        end
        idle(4);
        check("single_start", 32'(start_cnt - s0), 1);
        check("led", 32'(led), 32'(mregs[0]));
    endtask

    task automatic check_reset_outputs();
        check("rst_led", 32'(led), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_frame_err", 32'(frame_err), 0);
    endtask

    initial begin
        int         s0, e0, acc;
        logic [7:0] c, a, d, k, j;

        model_reset();
        idle(3);
        check_reset_outputs();
        reset = 1'b1;
        idle(2);

        // Directed frames: write, read-back, bad checksum, bad address, read of reg 1.
        run_frame(8'h01, 8'h00, 8'h5A, 8'h5B, 0, 0);
        run_frame(8'h02, 8'h00, 8'h00, 8'h02, 0, 0);
        run_frame(8'h01, 8'h01, 8'h33, 8'h00, 0, 0);
        run_frame(8'h01, 8'h05, 8'h00, 8'h04, 0, 0);
        run_frame(8'h02, 8'h01, 8'h00, 8'h03, 0, 0);

        // Junk then a truncated frame: the gap timeout must discard it silently.
        s0 = start_cnt;
        e0 = err_cnt;
        send_byte(8'h11, 2, acc);
        send_byte(8'h22, 2, acc);
        send_byte(SOF, 2, acc);
        send_byte(8'h01, 2, acc);
        send_byte(8'h00, 2, acc);
        send_byte(8'h0F, 2, acc);
        idle(TOUT + 20);
        check("timeout_no_start", 32'(start_cnt - s0), 0);
        check("timeout_no_err", 32'(err_cnt - e0), 0);
        check("timeout_led", 32'(led), 32'(mregs[0]));
        run_frame(8'h01, 8'h03, 8'hC3, 8'hC1, 0, 0);

        // Transmitter busy for 100 cycles, then a long but legal inter-byte gap.
        run_frame(8'h01, 8'h02, 8'h77, 8'h74, 100, 0);
        run_frame(8'h02, 8'h02, 8'h10, 8'h10, 0, int'(TOUT) - 20);

        // Randomized frames, with junk prefixes, 0xAA payload bytes and corrupt checksums.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                j = 8'($urandom_range(0, 254));
                if (j == SOF) j = 8'h55;
                send_byte(j, rg(), acc);
            end
            c = ($urandom_range(0, 9) < 4) ? 8'h01 :
                ($urandom_range(0, 9) < 8) ? 8'h02 : 8'($urandom);
            a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
            d = ($urandom_range(0, 5) == 0) ? SOF : 8'($urandom);
            k = c ^ a ^ d;
            if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
            run_frame(c, a, d, k, ($urandom_range(0, 7) == 0) ? 30 : 0, 0);
        end

        // Reset one cycle after AA 01: the tail of the frame is ignored.
        s0 = start_cnt;
        send_byte(SOF, 2, acc);
        send_byte(8'h01, 2, acc);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        send_byte(8'h00, 2, acc);
        send_byte(8'h5A, 2, acc);
        send_byte(8'h5B, 2, acc);
        idle(30);
        check("reset_tail_no_start", 32'(start_cnt - s0), 0);
        check("reset_tail_led", 32'(led), 0);

        // Reset while a response is waiting on a busy transmitter.
        s0 = start_cnt;
        tx_busy = 1'b1;
        send_byte(SOF, 2, acc);
        send_byte(8'h01, 2, acc);
        send_byte(8'h00, 2, acc);
        send_byte(8'h5A, 2, acc);
        send_byte(8'h5B, 2, acc);
        idle(5);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        tx_busy = 1'b0;
        model_reset();
        idle(20);
        check("resp_reset_no_start", 32'(start_cnt - s0), 0);
        check("resp_reset_led", 32'(led), 0);
        run_frame(8'h02, 8'h00, 8'h00, 8'h02, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
